// File: rtl/regbank_pkg.sv
// regbank_pkg: shared sizes and register address type for the register bank
package regbank_pkg;
  localparam int NUM_REGS = 32;
  localparam int REG_ADDR_W = 5;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/mux32to1_n.sv
// mux32to1_n: 32-way selector of one register out of the architectural array
module mux32to1_n
  import regbank_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] data_i [NUM_REGS-1:0],
  input  logic [REG_ADDR_W-1:0] sel_i,
  output logic [DATA_WIDTH-1:0] data_o
);
  // every 5-bit select names a real entry, so the output is never undefined
  always_comb data_o = data_i[sel_i];
endmodule

// File: rtl/regbank32_n.sv
// regbank32_n: 32-entry register bank with write-first read bypass and busy scoreboard
module regbank32_n
  import regbank_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [REG_ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  issue_en_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  output logic [DATA_WIDTH-1:0] rs1_data_o,
  output logic [DATA_WIDTH-1:0] rs2_data_o,
  output logic                  rs1_busy_o,
  output logic                  rs2_busy_o,
  output logic [DATA_WIDTH-1:0] regs_o [NUM_REGS-1:0],
  output logic [NUM_REGS-1:0]   busy_o
);
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS-1:0];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS-1:0];
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic [DATA_WIDTH-1:0] rs1_mux, rs2_mux;
  logic                  wr_live, rs1_hit, rs2_hit;
  assign wr_live = wr_en_i && (wr_addr_i != REG_ZERO);
  // next state: writeback updates data and clears busy, a later issue to the same entry re-sets busy
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_live) begin
      regs_d[wr_addr_i] = wr_data_i;
      busy_d[wr_addr_i] = 1'b0;
    end
    if (issue_en_i && issue_rd_i != REG_ZERO) busy_d[issue_rd_i] = 1'b1;
  end
  // state registers; x0 is never written so it stays at its reset value of zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end
  assign regs_o = regs_q;
  assign busy_o = busy_q;
  mux32to1_n #(.DATA_WIDTH(DATA_WIDTH)) u_rs1_mux (.data_i(regs_q), .sel_i(rs1_addr_i), .data_o(rs1_mux));
  mux32to1_n #(.DATA_WIDTH(DATA_WIDTH)) u_rs2_mux (.data_i(regs_q), .sel_i(rs2_addr_i), .data_o(rs2_mux));
  // read ports: x0 forced to zero, same-cycle writeback forwarded and treated as no longer pending
  always_comb begin
    rs1_hit    = wr_live && (wr_addr_i == rs1_addr_i);
    rs2_hit    = wr_live && (wr_addr_i == rs2_addr_i);
    rs1_data_o = (rs1_addr_i == REG_ZERO) ? '0 : rs1_hit ? wr_data_i : rs1_mux;
    rs2_data_o = (rs2_addr_i == REG_ZERO) ? '0 : rs2_hit ? wr_data_i : rs2_mux;
    rs1_busy_o = (rs1_addr_i != REG_ZERO) && busy_q[rs1_addr_i] && !rs1_hit;
    rs2_busy_o = (rs2_addr_i != REG_ZERO) && busy_q[rs2_addr_i] && !rs2_hit;
  end
endmodule

// File: tb/tb_regbank32_n.sv
// tb_regbank32_n: directed and model-checked bench for the register bank
module tb_regbank32_n;
  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        wr_en = 1'b0, issue_en = 1'b0;
  logic [4:0]  wr_addr = '0, issue_rd = '0, rs1_addr = '0, rs2_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rs1_data, rs2_data;
  logic        rs1_busy, rs2_busy;
  logic [31:0] regs [31:0];
  logic [31:0] busy;
  int          n_cmp = 0, n_err = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  regbank32_n #(.DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .issue_en_i(issue_en), .issue_rd_i(issue_rd), .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
    .rs1_data_o(rs1_data), .rs2_data_o(rs2_data), .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy),
    .regs_o(regs), .busy_o(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    wr_en = 1'b0;
    issue_en = 1'b0;
  endtask
  initial begin
    logic [31:0] e1, e2, v;
    logic [4:0]  a;
    #12 rst_ni = 1'b1;
    step();
    chk("reset_reg5", regs[5], 32'h0);
    chk("reset_busy", busy, 32'h0);
    // reset mid-cycle discards state immediately
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    step();
    idle();
    issue_en = 1'b1; issue_rd = 5;
    step();
    idle();
    #1;
    chk("pre_rst_reg5", regs[5], 32'hDEADBEEF);
    chk("pre_rst_busy5", {31'b0, busy[5]}, 32'h1);
    wr_en = 1'b1; wr_addr = 6; wr_data = 32'h77;
    #1 rst_ni = 1'b0;
    #1;
    chk("async_rst_reg5", regs[5], 32'h0);
    chk("async_rst_busy", busy, 32'h0);
    step();
    chk("rst_drops_wr", regs[6], 32'h0);
    idle();
    rst_ni = 1'b1;
    step();
    // x0 ignores writes and issues
    wr_en = 1'b1; wr_addr = 0; wr_data = 32'h1234;
    issue_en = 1'b1; issue_rd = 0; rs1_addr = 0;
    #1;
    chk("x0_rs1_data", rs1_data, 32'h0);
    chk("x0_rs1_busy", {31'b0, rs1_busy}, 32'h0);
    step();
    idle();
    #1;
    chk("x0_busy", busy, 32'h0);
    chk("x0_reg", regs[0], 32'h0);
    // write-first bypass on both ports
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'h11;
    step();
    wr_data = 32'h22; rs1_addr = 7; rs2_addr = 7;
    #1;
    chk("byp_rs1", rs1_data, 32'h22);
    chk("byp_rs2", rs2_data, 32'h22);
    chk("byp_regs_old", regs[7], 32'h11);
    step();
    idle();
    #1;
    chk("byp_regs_new", regs[7], 32'h22);
    chk("byp_rs1_after", rs1_data, 32'h22);
    // scoreboard set on issue, cleared by writeback with consistent bypass
    issue_en = 1'b1; issue_rd = 3; rs2_addr = 3;
    #1;
    chk("sb_same_cycle", {31'b0, rs2_busy}, 32'h0);
    step();
    idle();
    #1;
    chk("sb_busy_rs2", {31'b0, rs2_busy}, 32'h1);
    chk("sb_busy_vec", busy, 32'h0000_0008);
    wr_en = 1'b1; wr_addr = 3; wr_data = 32'h55;
    #1;
    chk("sb_wb_busy", {31'b0, rs2_busy}, 32'h0);
    chk("sb_wb_data", rs2_data, 32'h55);
    chk("sb_wb_vec_held", {31'b0, busy[3]}, 32'h1);
    step();
    idle();
    #1;
    chk("sb_cleared", {31'b0, busy[3]}, 32'h0);
    chk("sb_reg3", regs[3], 32'h55);
    // issue and writeback to the same busy entry: issue wins
    issue_en = 1'b1; issue_rd = 9;
    step();
    wr_en = 1'b1; wr_addr = 9; wr_data = 32'hAA; rs1_addr = 9;
    #1;
    chk("col_rs1_busy", {31'b0, rs1_busy}, 32'h0);
    chk("col_rs1_data", rs1_data, 32'hAA);
    step();
    idle();
    #1;
    chk("col_busy9", {31'b0, busy[9]}, 32'h1);
    chk("col_reg9", regs[9], 32'hAA);
    // sweep all entries
    for (int r = 1; r < 32; r++) begin
      wr_en = 1'b1; wr_addr = 5'(r); wr_data = 32'(r) * 32'h01010101;
      step();
    end
    idle();
    for (int r = 0; r < 32; r++) begin
      rs1_addr = 5'(r); rs2_addr = 5'(31 - r);
      #1;
      chk("sweep_rs1", rs1_data, 32'(r) * 32'h01010101);
      chk("sweep_rs2", rs2_data, 32'(31 - r) * 32'h01010101);
      chk("sweep_regs", regs[r], 32'(r) * 32'h01010101);
    end
    chk("sweep_busy", busy, 32'h0);
    // random traffic against a reference model
    for (int r = 0; r < 32; r++) m_regs[r] = 32'(r) * 32'h01010101;
    m_busy = '0;
    for (int c = 0; c < 10000; c++) begin
      rs1_addr = 5'($urandom_range(0, 31));
      rs2_addr = 5'($urandom_range(0, 31));
      wr_en = 1'($urandom_range(0, 1));
      a = 5'($urandom_range(0, 31));
      wr_addr = ($urandom_range(0, 2) == 0) ? rs1_addr : a;
      wr_data = $urandom;
      issue_en = 1'($urandom_range(0, 1));
      issue_rd = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      #1;
      e1 = (rs1_addr == 0) ? 32'h0 : (wr_en && wr_addr == rs1_addr) ? wr_data : m_regs[rs1_addr];
      e2 = (rs2_addr == 0) ? 32'h0 : (wr_en && wr_addr == rs2_addr) ? wr_data : m_regs[rs2_addr];
      chk("rnd_rs1_data", rs1_data, e1);
      chk("rnd_rs2_data", rs2_data, e2);
      v = {31'b0, (rs1_addr != 0) && m_busy[rs1_addr] && !(wr_en && wr_addr == rs1_addr)};
      chk("rnd_rs1_busy", {31'b0, rs1_busy}, v);
      v = {31'b0, (rs2_addr != 0) && m_busy[rs2_addr] && !(wr_en && wr_addr == rs2_addr)};
      chk("rnd_rs2_busy", {31'b0, rs2_busy}, v);
      step();
      if (wr_en && wr_addr != 0) begin
        m_regs[wr_addr] = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      chk("rnd_busy_vec", busy, m_busy);
      if (c % 64 == 0) chk("rnd_regs", regs[a], m_regs[a]);
    end
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
